// File: rtl/procyon_sram_ctrl.sv
// Request-side controller for the external 1M x 16 asynchronous SRAM.
// Each DATA_WIDTH request is split into DATA_WIDTH/16 two-phase beats with registered pin outputs.
module procyon_sram_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_we,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_req_data,
  input  logic [DATA_WIDTH/8-1:0] i_req_byte_en,
  output logic                    o_rsp_valid,
  output logic [DATA_WIDTH-1:0]   o_rsp_data,
  output logic [19:0]             o_sram_addr,
  output logic [15:0]             o_sram_dq,
  output logic                    o_sram_dq_oe,
  input  logic [15:0]             i_sram_dq,
  output logic                    o_sram_ce_n,
  output logic                    o_sram_oe_n,
  output logic                    o_sram_we_n,
  output logic                    o_sram_lb_n,
  output logic                    o_sram_ub_n
);

  localparam int N    = DATA_WIDTH / 16;
  localparam int BW   = (N > 1) ? $clog2(N) : 1;
  localparam int BE_W = DATA_WIDTH / 8;
  // Word-address bits below the request alignment are forced to zero.
  localparam logic [19:0] ALIGN_MASK = ~((20'd1 << $clog2(N)) - 20'd1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PH_A = 2'd1;
  localparam logic [1:0] PH_B = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]            state;
  logic [BW-1:0]         beat;
  logic                  we_q;
  logic [19:0]           base_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [BE_W-1:0]       be_q;

  logic                  accept;
  logic                  last_beat;
  logic                  load_beat;
  logic [19:0]           req_base;
  logic [BW-1:0]         nb_idx;
  logic                  nb_we;
  logic [19:0]           nb_addr;
  logic [15:0]           nb_dq;
  logic [1:0]            nb_be;
  logic                  unused_addr;

  function automatic logic [15:0] lane_data(input logic [DATA_WIDTH-1:0] d, input int b);
    lane_data = d[16*b +: 16];
  endfunction

  function automatic logic [1:0] lane_be(input logic [BE_W-1:0] be, input int b);
    lane_be = be[2*b +: 2];
  endfunction

  assign unused_addr = ^i_req_addr;
  assign o_req_ready = (state == IDLE);
  assign req_base    = i_req_addr[20:1] & ALIGN_MASK;
  assign accept      = i_req_valid && (state == IDLE);
  assign last_beat   = (beat == BW'(N - 1));
  assign load_beat   = accept || ((state == PH_B) && !last_beat);

  // Pin values for the PH_A of the beat about to start: beat 0 of a fresh request or the next beat.
  always_comb begin
    nb_idx  = accept ? '0 : beat + BW'(1);
    nb_we   = accept ? i_req_we : we_q;
    nb_addr = (accept ? req_base : base_q) + 20'(nb_idx);
    nb_dq   = lane_data(accept ? i_req_data : data_q, int'(nb_idx));
    nb_be   = lane_be(accept ? i_req_byte_en : be_q, int'(nb_idx));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      beat         <= '0;
      we_q         <= 1'b0;
      base_q       <= '0;
      data_q       <= '0;
      be_q         <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_data   <= '0;
      o_sram_addr  <= '0;
      o_sram_dq    <= '0;
      o_sram_dq_oe <= 1'b0;
      o_sram_ce_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
      o_sram_we_n  <= 1'b1;
      o_sram_lb_n  <= 1'b1;
      o_sram_ub_n  <= 1'b1;
    end else begin
      o_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            state  <= PH_A;
            beat   <= '0;
            we_q   <= i_req_we;
            base_q <= req_base;
            data_q <= i_req_data;
            be_q   <= i_req_byte_en;
          end
        end
        PH_A: begin
          state       <= PH_B;
          o_sram_we_n <= 1'b1;
        end
        PH_B: begin
          if (!we_q) o_rsp_data[16*int'(beat) +: 16] <= i_sram_dq;
          if (last_beat) begin
            state        <= RESP;
            o_rsp_valid  <= 1'b1;
            o_sram_dq_oe <= 1'b0;
            o_sram_ce_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_we_n  <= 1'b1;
            o_sram_lb_n  <= 1'b1;
            o_sram_ub_n  <= 1'b1;
          end else begin
            state <= PH_A;
            beat  <= nb_idx;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (load_beat) begin
        o_sram_addr  <= nb_addr;
        o_sram_ce_n  <= 1'b0;
        o_sram_oe_n  <= nb_we;
        o_sram_we_n  <= ~nb_we;
        o_sram_dq_oe <= nb_we;
        o_sram_lb_n  <= nb_we ? ~nb_be[0] : 1'b0;
        o_sram_ub_n  <= nb_we ? ~nb_be[1] : 1'b0;
        if (nb_we) o_sram_dq <= nb_dq;
      end
    end
  end

endmodule

// File: tb/tb_procyon_sram_ctrl.sv
// Bench for procyon_sram_ctrl (DATA_WIDTH=32): table vectors, reset/back-to-back sequences,
// and random requests checked against a byte-level reference memory.
module tb_procyon_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_data;
  logic [3:0]  i_req_byte_en;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_data;
  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_dq;
  logic        o_sram_dq_oe;
  logic [15:0] i_sram_dq;
  logic        o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n;

  int n_chk  = 0;
  int n_pass = 0;

  procyon_sram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .i_req_byte_en(i_req_byte_en),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_sram_addr(o_sram_addr), .o_sram_dq(o_sram_dq), .o_sram_dq_oe(o_sram_dq_oe),
    .i_sram_dq(i_sram_dq),
    .o_sram_ce_n(o_sram_ce_n), .o_sram_oe_n(o_sram_oe_n), .o_sram_we_n(o_sram_we_n),
    .o_sram_lb_n(o_sram_lb_n), .o_sram_ub_n(o_sram_ub_n)
  );

  always #5 clk = ~clk;

  // Pin-level SRAM: writes land on the clock edge while we_n is low.
  logic [15:0] sram [0:1048575];
  initial for (int i = 0; i < 1048576; i++) sram[i] = 16'h0000;
  always @(posedge clk) begin
    if (!o_sram_ce_n && !o_sram_we_n) begin
      if (!o_sram_lb_n) sram[o_sram_addr][7:0]  <= o_sram_dq[7:0];
      if (!o_sram_ub_n) sram[o_sram_addr][15:8] <= o_sram_dq[15:8];
    end
  end
  assign i_sram_dq = (!o_sram_ce_n && !o_sram_oe_n) ? sram[o_sram_addr] : 16'h0000;

  // Reference: byte-addressed memory of the 2 MB device.
  logic [7:0] ref_mem [int];

  function automatic int byte_key(input logic [31:0] addr, input int k);
    int word;
    word = (((addr >> 1) & 32'h000F_FFFE) + k / 2) & 32'h000F_FFFF;
    return word * 2 + (k % 2);
  endfunction

  task automatic ref_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    for (int k = 0; k < 4; k++)
      if (be[k]) ref_mem[byte_key(addr, k)] = data[8*k +: 8];
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    logic [31:0] r;
    int key;
    r = 32'h0;
    for (int k = 0; k < 4; k++) begin
      key = byte_key(addr, k);
      r[8*k +: 8] = ref_mem.exists(key) ? ref_mem[key] : 8'h00;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [5:0] ctl();
    return {o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n, o_sram_dq_oe};
  endfunction

  // Bus rules every cycle: never oe_n and we_n both low; dq_oe only during a write beat.
  always @(negedge clk) begin
    if (!rst)
      chk("pin_rules", ((!o_sram_oe_n && !o_sram_we_n) ||
                        (o_sram_dq_oe && (!o_sram_oe_n || o_sram_ce_n))), 1'b0);
  end

  // One request from a ready cycle through to ready again; busy cycles present a decoy request.
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input logic [19:0] a0, input logic [31:0] exp_rsp);
    int guard;
    int b;
    logic [5:0] ectl;
    guard = 0;
    while (!o_req_ready && guard < 20) begin @(negedge clk); guard++; end
    chk("ready_wait", o_req_ready, 1'b1);
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_data = data; i_req_byte_en = be;
    @(posedge clk);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        i_req_we = ~we; i_req_addr = $urandom; i_req_data = $urandom; i_req_byte_en = 4'hF;
      end
      if (cyc == 5) i_req_valid = 1'b0;
      if (cyc <= 4) begin
        b = (cyc - 1) / 2;
        chk("ready_busy", o_req_ready, 1'b0);
        chk("rsp_early", o_rsp_valid, 1'b0);
        chk("beat_addr", o_sram_addr, (32'(a0) + b) & 32'h000F_FFFF);
        if (we) begin
          ectl = {1'b0, 1'b1, (cyc % 2 == 0), ~be[2*b], ~be[2*b+1], 1'b1};
          chk("wr_dq", o_sram_dq, data[16*b +: 16]);
        end else begin
          ectl = 6'b001000;
        end
        chk("beat_ctl", ctl(), ectl);
      end else begin
        chk("idle_ctl", ctl(), 6'b111110);
        chk("addr_hold", o_sram_addr, (32'(a0) + 1) & 32'h000F_FFFF);
        chk(cyc == 5 ? "rsp_valid" : "rsp_drop", o_rsp_valid, cyc == 5);
        chk(cyc == 5 ? "ready_resp" : "ready_back", o_req_ready, cyc == 6);
        if (cyc == 5 && !we) chk("rsp_data", o_rsp_data, exp_rsp);
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [19:0] a0;
    logic [31:0] rsp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [19:0] pool [6];
    logic [31:0] a, d;
    logic        w;
    logic [3:0]  be;
    int          rsp_seen;
    pool = '{20'h00800, 20'h10000, 20'hFFFFE, 20'h00000, 20'h04000, 20'h12345};

    tbl[0] = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 20'h00800, 32'h0};
    tbl[1] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 20'h00800, 32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 32'h0000_1000, 32'h1122_3344, 4'h4, 20'h00800, 32'h0};
    tbl[3] = '{1'b0, 32'h0000_1003, 32'h0,         4'h0, 20'h00800, 32'hDE22_BEEF};
    tbl[4] = '{1'b1, 32'h001F_FFFC, 32'hCAFE_F00D, 4'hF, 20'hFFFFE, 32'h0};
    tbl[5] = '{1'b1, 32'h0020_0000, 32'hA5A5_5A5A, 4'h3, 20'h00000, 32'h0};
    tbl[6] = '{1'b0, 32'h001F_FFFC, 32'h0,         4'h0, 20'hFFFFE, 32'hCAFE_F00D};
    tbl[7] = '{1'b0, 32'hFFE0_0002, 32'h0,         4'h0, 20'h00000, 32'h0000_5A5A};

    rst = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0;
    i_req_addr = '0; i_req_data = '0; i_req_byte_en = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", ctl(), 6'b111110);
    chk("rst_ready", o_req_ready, 1'b1);
    chk("rst_rsp_valid", o_rsp_valid, 1'b0);
    chk("rst_rsp_data", o_rsp_data, 32'h0);
    chk("rst_addr_dq", {o_sram_addr, o_sram_dq}, 36'h0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_req(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].be, tbl[i].a0, tbl[i].rsp);
      if (tbl[i].we) ref_write(tbl[i].addr, tbl[i].data, tbl[i].be);
    end

    // Back-to-back reads with valid held: acceptances 6 cycles apart.
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h0000_1000;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(negedge clk);
      chk("b2b_ready", o_req_ready, (k % 6) == 0);
      chk("b2b_rsp", o_rsp_valid, (k % 6) == 5);
      if (k == 5 || k == 11) chk("b2b_data", o_rsp_data, ref_read(32'h0000_1000));
      if (k == 12) i_req_valid = 1'b0;
    end

    // Reset in the middle of a write: controls drop at once, no response follows.
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 32'h0000_3000;
    i_req_data = 32'h0BAD_0BAD; i_req_byte_en = 4'hF;
    @(posedge clk);
    #3 rst = 1'b1;
    i_req_valid = 1'b0;
    #1;
    chk("mid_rst_ctl", ctl(), 6'b111110);
    chk("mid_rst_ready", o_req_ready, 1'b1);
    chk("mid_rst_rsp", o_rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rsp_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_rsp_valid) rsp_seen++;
    end
    chk("mid_rst_no_rsp", rsp_seen, 0);

    for (int r = 0; r < 24; r++) begin
      a = $urandom;
      a[20:1] = pool[$urandom_range(0, 5)];
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(0, 15));
      run_req(w, a, d, be, 20'((a >> 1) & 32'h000F_FFFE), ref_read(a));
      if (w) ref_write(a, d, be);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
